rob_flush_ctrl: RTL
===================

# rob_flush_ctrl

Sequencer that sits between the ROB, the free list, the dispatch stage and the map table. It turns the ROB's single-cycle `branch_haz`/`free_list_haz` flush indication into an ordered recovery sequence:
- flush pulse
- paced return of squashed physical tags to the free list, `N_WAY` per cycle
- architectural map restore pulse
- resume

In normal operation it also forwards retired `tag_old` values to the free list with a ready/valid handshake.

## Interface
- `N_ROB`, 8, ROB entries (width of the captured flush vector)
- `N_WAY`, 2, superscalar width; free-port lanes
- `CDB_BITS`, 6, physical tag width; tag 0 means "no register"
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `branch_haz`  in  1  ROB mispredict-retire indication (one cycle)
- `free_list_haz`  in  N_ROB×CDB_BITS  squashed tags from ROB, valid when `branch_haz`=1
- `retire_valid`  in  N_WAY  ROB retire lanes
- `retire_told`  in  N_WAY×CDB_BITS  retired old tags
- `free_ready`  in  1  free list accepts the current free-port beat
- `free_valid`  out  N_WAY  registered free-port lane valids
- `free_tag`  out  N_WAY×CDB_BITS  registered free-port tags
- `retire_stall`  out  1  ROB must not retire this cycle
- `dispatch_stall`  out  1  dispatch must not issue this cycle
- `flush`  out  1  one-cycle squash pulse to RS/map table/fetch
- `restore_map`  out  1  one-cycle copy arch map to speculative map
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, FLUSH, DRAIN, RESTORE (2-bit register).
- **Free port (all states).**
  - The port "advances" when `!(|free_valid) || free_ready`.
  - When it does not advance, `free_valid`/`free_tag` hold.
  - `retire_stall = (|free_valid) && !free_ready`.
- **IDLE.**
  - On advance, lane i loads `retire_told[i]` with valid = `retire_valid[i] && retire_told[i]!=0`.
  - If `branch_haz`=1: load shadow vector ← `free_list_haz` and shadow mask bit j ← (`free_list_haz[j]`≠0). Go to FLUSH.
- **FLUSH** (exactly one cycle).
  - `flush`=1.
  - No retire lanes are loaded; the port only drains its existing beat.
  - Next state is DRAIN if the mask is non-zero, else RESTORE.
- **DRAIN.**
  - On each advance, select the up to `N_WAY` lowest-index set mask bits.
  - Place them in lanes 0..N_WAY-1 in ascending index order; unused lanes get valid=0 and tag=0.
  - Clear the selected mask bits.
  - When the mask becomes zero on an advance, go to RESTORE.
- **RESTORE** (exactly one cycle).
  - `restore_map`=1; port drains only. Next state: IDLE.
- `dispatch_stall = branch_haz || state≠IDLE`. It is combinational, so dispatch is blocked in the branch cycle itself.
- `branch_haz` outside IDLE is illegal and ignored (bench asserts it never occurs).
- Duplicate tags in `free_list_haz` are forwarded as-is; dedup is the free list's concern.

## Timing
- Reset (async, `reset`=0): state=IDLE; mask=0; shadow=0; `free_valid`=0; `free_tag`=0; `flush`=0; `restore_map`=0; `busy`=0.
- The combinational outputs follow from those reset values: `retire_stall`=0, and `dispatch_stall`=`branch_haz`.
- Reset asserted mid-DRAIN drops all pending tags immediately; the next rising edge after deassertion starts from IDLE.
- Retire→free port latency: 1 cycle (registered) when the port advances.
- Mispredict at cycle T:
  - T+1: FLUSH.
  - T+2 … T+1+⌈k/N_WAY⌉: DRAIN, where k is the count of non-zero tags and `free_ready` stays high.
  - Next cycle: RESTORE.
  - Following cycle: IDLE.
- With k=0: T+1 FLUSH, T+2 RESTORE, T+3 IDLE.
- Retire tolds presented in cycle T (the branch's own lane) appear on the free port at T+1.
- `free_ready` low stretches DRAIN cycle-for-cycle; FLUSH and RESTORE are never stretched.

## Configuration
- `ROB_FLUSH_STATS_EN` defined: adds outputs `flush_count` (16 bit) and `drain_cycles` (16 bit).
  - `flush_count` increments on FLUSH entry.
  - `drain_cycles` increments every cycle in DRAIN.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with `reset`=0 mid-DRAIN (mask holding 3 tags) → next cycle all outputs 0, `busy`=0; after release, no stale tags are emitted.
- IDLE, `retire_valid`=2'b11, tolds 5/0, `free_ready`=1 → next cycle `free_valid`=2'b01, `free_tag[0]`=5.
- `branch_haz` with `free_list_haz`={0,9,0,12,7,0,3,0} (index 0..7), `free_ready`=1:
  - `dispatch_stall`=1 in the branch cycle.
  - FLUSH pulse, then DRAIN beats {9,12}, {7,3}, then RESTORE pulse, then IDLE. Total 5 cycles after T.
- Same flush with `free_ready`=0 for 3 cycles during the first DRAIN beat → {9,12} held for 4 cycles, `retire_stall`=1 throughout, and order is unchanged.
- `branch_haz` with all-zero `free_list_haz` → FLUSH, RESTORE, IDLE with no free-port valids.
- `ROB_FLUSH_STATS_EN`: two back-to-back flushes of 3 tags each → `flush_count`=2, `drain_cycles`=4.

Source files
------------

// File: rtl/rob_flush_ctrl.sv
// rob_flush_ctrl
//
// Recovery sequencer between the ROB, the free list, dispatch and the map
// table. A single-cycle branch_haz from the ROB becomes an ordered sequence:
//   FLUSH   - one-cycle flush pulse to RS / map table / fetch
//   DRAIN   - squashed physical tags returned to the free list, N_WAY per beat
//   RESTORE - one-cycle restore_map pulse (arch map -> speculative map)
//   IDLE    - normal operation, retired tag_old values forwarded to free list
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset (asserted when 0)
//   branch_haz     ROB mispredict-retire indication, one cycle
//   free_list_haz  squashed tags from the ROB, valid with branch_haz
//   retire_valid   ROB retire lanes
//   retire_told    retired old physical tags, one per lane
//   free_ready     free list accepts the current free-port beat
//   free_valid     registered free-port lane valids
//   free_tag       registered free-port tags
//   retire_stall   ROB must not retire this cycle (free port is blocked)
//   dispatch_stall dispatch must not issue this cycle
//   flush          one-cycle squash pulse
//   restore_map    one-cycle map restore pulse
//   busy           sequencer is not in IDLE
//
// Optional build macro ROB_FLUSH_STATS_EN adds two saturating 16-bit
// counters: flush_count (flushes started) and drain_cycles (cycles in DRAIN).
// With the macro undefined those ports and counters do not exist.

module rob_flush_ctrl #(
  parameter int N_ROB    = 8,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               branch_haz,
  input  logic [N_ROB-1:0][CDB_BITS-1:0]     free_list_haz,
  input  logic [N_WAY-1:0]                   retire_valid,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]     retire_told,
  input  logic                               free_ready,
  output logic [N_WAY-1:0]                   free_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]     free_tag,
  output logic                               retire_stall,
  output logic                               dispatch_stall,
  output logic                               flush,
  output logic                               restore_map,
  output logic                               busy
`ifdef ROB_FLUSH_STATS_EN
  ,
  output logic [15:0]                        flush_count,
  output logic [15:0]                        drain_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_RESTORE = 2'd3
  } state_t;

  state_t                            state;
  logic [N_ROB-1:0][CDB_BITS-1:0]    shadow;
  logic [N_ROB-1:0]                  mask;

  logic                              advance;
  logic [N_ROB-1:0]                  haz_nonzero;
  logic [N_WAY-1:0]                  retire_lane_valid;
  logic [N_WAY-1:0]                  drain_valid;
  logic [N_WAY-1:0][CDB_BITS-1:0]    drain_tag;
  logic [N_ROB-1:0]                  mask_next;

  // The free port moves on when it is empty or the free list takes the beat;
  // otherwise the current beat holds and the ROB is told not to retire.
  assign advance        = !(|free_valid) || free_ready;
  assign retire_stall   = (|free_valid) && !free_ready;
  assign dispatch_stall = branch_haz || (state != S_IDLE);

  // Only non-zero squashed tags name a real register, so only those get a
  // mask bit and are ever returned during DRAIN.
  always_comb begin
    haz_nonzero = '0;
    for (int j = 0; j < N_ROB; j++) begin
      haz_nonzero[j] = |free_list_haz[j];
    end
  end

  // A retire lane carrying tag 0 has no old register to free.
  always_comb begin
    retire_lane_valid = '0;
    for (int i = 0; i < N_WAY; i++) begin
      retire_lane_valid[i] = retire_valid[i] && (|retire_told[i]);
    end
  end

  // Pick the lowest-index pending mask bits, at most N_WAY of them, and pack
  // them into lanes 0.. in ascending ROB index order. Lanes left over stay
  // invalid with tag 0. mask_next is the mask with the picked bits removed.
  always_comb begin
    int picked;
    drain_valid = '0;
    drain_tag   = '0;
    mask_next   = mask;
    picked      = 0;
    for (int j = 0; j < N_ROB; j++) begin
      if (mask[j]) begin
        for (int l = 0; l < N_WAY; l++) begin
          if (picked == l) begin
            drain_valid[l] = 1'b1;
            drain_tag[l]   = shadow[j];
            mask_next[j]   = 1'b0;
          end
        end
        picked = picked + 1;
      end
    end
  end

  // Sequencer and free port. flush, restore_map and busy are registered and
  // set on the edge that enters the matching state, so they line up exactly
  // with the state register. FLUSH and RESTORE last one cycle regardless of
  // free_ready; only DRAIN waits for the port to advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      shadow      <= '0;
      mask        <= '0;
      free_valid  <= '0;
      free_tag    <= '0;
      flush       <= 1'b0;
      restore_map <= 1'b0;
      busy        <= 1'b0;
    end else begin
      flush       <= 1'b0;
      restore_map <= 1'b0;
      case (state)
        S_IDLE: begin
          if (advance) begin
            free_valid <= retire_lane_valid;
            free_tag   <= retire_told;
          end
          if (branch_haz) begin
            shadow <= free_list_haz;
            mask   <= haz_nonzero;
            state  <= S_FLUSH;
            flush  <= 1'b1;
            busy   <= 1'b1;
          end
        end

        S_FLUSH: begin
          if (advance) begin
            free_valid <= '0;
            free_tag   <= '0;
          end
          if (|mask) begin
            state <= S_DRAIN;
          end else begin
            state       <= S_RESTORE;
            restore_map <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (advance) begin
            free_valid <= drain_valid;
            free_tag   <= drain_tag;
            mask       <= mask_next;
            if (mask_next == '0) begin
              state       <= S_RESTORE;
              restore_map <= 1'b1;
            end
          end
        end

        S_RESTORE: begin
          if (advance) begin
            free_valid <= '0;
            free_tag   <= '0;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROB_FLUSH_STATS_EN
  // Statistics: a flush is counted on the edge entering FLUSH, and every
  // cycle spent in DRAIN (stretched beats included) adds one drain cycle.
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_count  <= '0;
      drain_cycles <= '0;
    end else begin
      if ((state == S_IDLE) && branch_haz && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
      if ((state == S_DRAIN) && (drain_cycles != 16'hFFFF)) begin
        drain_cycles <= drain_cycles + 16'd1;
      end
    end
  end
`endif

endmodule
